// File: rtl/ecc_decoder_pipe.sv
// SECDED Hamming decoder/corrector for the memory read path.
// Stage 1 registers the codeword with its syndrome and overall parity.
// Stage 2 registers the corrected payload and the error flags.
// The whole pipe stalls as a unit when the consumer holds off.
module ecc_decoder_pipe #(
  parameter int data_bit_width      = 64,
  parameter int redundant_bit_width = 8,
  parameter int counter_width       = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
  input  logic                                        dec_in_valid,
  output logic                                        dec_in_ready,
  output logic [data_bit_width-1:0]                   dec_data_out,
  output logic                                        dec_out_valid,
  input  logic                                        dec_out_ready,
  output logic                                        dec_err_single,
  output logic                                        dec_err_double,
  output logic [redundant_bit_width-2:0]              dec_syndrome,
  output logic [counter_width-1:0]                    ce_count,
  output logic [counter_width-1:0]                    ue_count,
  input  logic                                        cnt_clear
);

  localparam int N      = data_bit_width + redundant_bit_width;
  localparam int SW     = redundant_bit_width - 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [N-1:0]  cw;
    logic [SW-1:0] syn;
    logic          par;
  } s1_t;

  typedef struct packed {
    logic [data_bit_width-1:0] data;
    logic [SW-1:0]             syn;
    logic                      single;
    logic                      dbl;
  } s2_t;

  // Syndrome bit k covers every position whose index has bit k set,
  // the check bit included, so a clean word yields zero.
  function automatic logic [SW-1:0] calc_syn(input logic [N-1:0] cw);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < SW; k++)
      for (int p = 0; p < N; p++)
        if (((p >> k) & 1) == 1) s[k] = s[k] ^ cw[p];
    return s;
  endfunction

  // Data occupies every non-power-of-two position above 0, in order.
  function automatic logic [data_bit_width-1:0] extract(input logic [N-1:0] cw);
    logic [data_bit_width-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p];
        j++;
      end
    return d;
  endfunction

  logic [STAGES:1] vld_pipe;
  s1_t             s1;
  s2_t             s2, s2_next;
  logic            en, in_range, single, dbl, out_xfer;
  logic [N-1:0]    fixed;

  assign en           = !vld_pipe[STAGES] || dec_out_ready;
  assign dec_in_ready = en;
  assign out_xfer     = vld_pipe[STAGES] && dec_out_ready;

  // Classify the stage-1 word and flip the indicated position when correctable.
  always_comb begin
    s2_next  = '0;
    fixed    = s1.cw;
    in_range = (int'(s1.syn) < N);
    single   = s1.par && in_range;
    dbl      = (s1.par && !in_range) || (!s1.par && (s1.syn != '0));
    if (single) fixed[s1.syn] = ~fixed[s1.syn];
    s2_next.data   = extract(fixed);
    s2_next.syn    = s1.syn;
    s2_next.single = single && vld_pipe[1];
    s2_next.dbl    = dbl && vld_pipe[1];
  end

  // Both stages advance together whenever the output slot can take a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], dec_in_valid};
      s1.cw    <= dec_data_in;
      s1.syn   <= calc_syn(dec_data_in);
      s1.par   <= ^dec_data_in;
      s2       <= s2_next;
    end
  end

  assign dec_out_valid  = vld_pipe[STAGES];
  assign dec_data_out   = s2.data;
  assign dec_syndrome   = s2.syn;
  assign dec_err_single = s2.single;
  assign dec_err_double = s2.dbl;

  // Saturating error counters, bumped on output transfers; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (out_xfer) begin
      if (s2.single && (ce_count != '1)) ce_count <= ce_count + 1'b1;
      if (s2.dbl && (ue_count != '1))    ue_count <= ue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_decoder_pipe.sv
// Directed bench for ecc_decoder_pipe: a full-width counter instance and a
// 2-bit counter instance share all inputs so saturation shows up quickly.
module tb_ecc_decoder_pipe;
  localparam int DW = 64;
  localparam int RW = 8;
  localparam int N  = DW + RW;
  localparam int SW = RW - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, dec_in_valid, dec_out_ready, cnt_clear;
  logic [N-1:0]  dec_data_in;
  logic          dec_in_ready, dec_out_valid, dec_err_single, dec_err_double;
  logic [DW-1:0] dec_data_out;
  logic [SW-1:0] dec_syndrome;
  logic [15:0]   ce_count, ue_count;

  logic          in_ready2, out_valid2, sg2, db2;
  logic [DW-1:0] data2;
  logic [SW-1:0] syn2;
  logic [1:0]    ce2, ue2;

  int tests = 0;
  int fails = 0;

  ecc_decoder_pipe #(.data_bit_width(DW), .redundant_bit_width(RW), .counter_width(16)) dut (
    .clk(clk), .rst(rst), .dec_data_in(dec_data_in), .dec_in_valid(dec_in_valid),
    .dec_in_ready(dec_in_ready), .dec_data_out(dec_data_out), .dec_out_valid(dec_out_valid),
    .dec_out_ready(dec_out_ready), .dec_err_single(dec_err_single), .dec_err_double(dec_err_double),
    .dec_syndrome(dec_syndrome), .ce_count(ce_count), .ue_count(ue_count), .cnt_clear(cnt_clear));

  ecc_decoder_pipe #(.data_bit_width(DW), .redundant_bit_width(RW), .counter_width(2)) dut2 (
    .clk(clk), .rst(rst), .dec_data_in(dec_data_in), .dec_in_valid(dec_in_valid),
    .dec_in_ready(in_ready2), .dec_data_out(data2), .dec_out_valid(out_valid2),
    .dec_out_ready(dec_out_ready), .dec_err_single(sg2), .dec_err_double(db2),
    .dec_syndrome(syn2), .ce_count(ce2), .ue_count(ue2), .cnt_clear(cnt_clear));

  // Reference encoder: data into non-power-of-two slots, then check bits, then overall parity.
  function automatic logic [N-1:0] enc(input logic [DW-1:0] d);
    logic [N-1:0] cw;
    int j;
    logic b;
    cw = '0;
    j  = 0;
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    for (int k = 0; k < SW; k++) begin
      b = 1'b0;
      for (int p = 1; p < N; p++)
        if ((((p >> k) & 1) == 1) && (p != (1 << k))) b = b ^ cw[p];
      cw[1 << k] = b;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [N-1:0] flip(input logic [N-1:0] cw, input int pos);
    logic [N-1:0] one;
    one = '0;
    one[pos] = 1'b1;
    return cw ^ one;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated word through an empty pipe; optional clear during its output transfer.
  task automatic xact(input string tag, input logic [N-1:0] cw, input logic [DW-1:0] ed,
                      input logic [SW-1:0] es, input logic esg, input logic edb, input logic clr);
    dec_data_in  = cw;
    dec_in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(dec_in_ready), 64'd1);
    step();
    dec_in_valid = 1'b0;
    dec_data_in  = '0;
    #1;
    chk({tag, " early valid"}, 64'(dec_out_valid), 64'd0);
    step();
    cnt_clear = clr;
    #1;
    chk({tag, " data"}, dec_data_out, ed);
    chk({tag, " syn"}, 64'(dec_syndrome), 64'(es));
    chk({tag, " vld/single/double"}, 64'({dec_out_valid, dec_err_single, dec_err_double}),
        64'({1'b1, esg, edb}));
    chk({tag, " dut2 data"}, data2, ed);
    chk({tag, " dut2 flags"}, 64'({out_valid2, sg2, db2, syn2, in_ready2}),
        64'({1'b1, esg, edb, es, 1'b1}));
    step();
    cnt_clear = 1'b0;
  endtask

  logic [DW-1:0] d, a, b, c, e;
  logic [N-1:0]  cw, w0, w1, w2, w3;

  initial begin
    rst = 1'b1; dec_in_valid = 1'b0; dec_out_ready = 1'b1; cnt_clear = 1'b0; dec_data_in = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst out_valid", 64'(dec_out_valid), 64'd0);
    chk("rst data", dec_data_out, 64'd0);
    chk("rst flags", 64'({dec_err_single, dec_err_double}), 64'd0);
    chk("rst syn", 64'(dec_syndrome), 64'd0);
    chk("rst counters", 64'({ce_count, ue_count}), 64'd0);
    chk("rst in_ready", 64'(dec_in_ready), 64'd1);

    d  = 64'h0123456789ABCDEF;
    cw = enc(d);

    xact("clean", cw, d, 7'd0, 1'b0, 1'b0, 1'b0);
    chk("clean counters", 64'({ce_count, ue_count}), 64'd0);
    xact("pos3", flip(cw, 3), d, 7'd3, 1'b1, 1'b0, 1'b0);
    chk("pos3 ce", 64'(ce_count), 64'd1);
    xact("pos0", flip(cw, 0), d, 7'd0, 1'b1, 1'b0, 1'b0);
    chk("pos0 ce", 64'(ce_count), 64'd2);
    xact("pos64", flip(cw, 64), d, 7'h40, 1'b1, 1'b0, 1'b0);
    chk("pos64 ce", 64'(ce_count), 64'd3);
    chk("pos64 ce2", 64'(ce2), 64'd3);
    xact("pos71", flip(cw, 71), d, 7'h47, 1'b1, 1'b0, 1'b0);
    chk("pos71 ce", 64'(ce_count), 64'd4);
    chk("ce2 saturated", 64'(ce2), 64'd3);
    xact("dbl3_5", flip(flip(cw, 3), 5), d ^ 64'h3, 7'h06, 1'b0, 1'b1, 1'b0);
    chk("dbl3_5 counters", 64'({ce_count, ue_count}), 64'({16'd4, 16'd1}));
    xact("oor72", flip(flip(flip(cw, 0), 8), 64), d, 7'h48, 1'b0, 1'b1, 1'b0);
    chk("oor72 ue", 64'(ue_count), 64'd2);
    xact("oor127", flip(flip(flip(flip(flip(flip(flip(cw, 1), 2), 4), 8), 16), 32), 64),
         d, 7'h7F, 1'b0, 1'b1, 1'b0);
    chk("oor127 ue", 64'(ue_count), 64'd3);
    xact("dbl9_10", flip(flip(cw, 9), 10), d ^ 64'h30, 7'h03, 1'b0, 1'b1, 1'b0);
    chk("dbl9_10 ue", 64'(ue_count), 64'd4);
    chk("ue2 saturated", 64'(ue2), 64'd3);
    xact("clr", flip(cw, 6), d, 7'd6, 1'b1, 1'b0, 1'b1);
    chk("clr counters", 64'({ce_count, ue_count}), 64'd0);
    chk("clr counters2", 64'({ce2, ue2}), 64'd0);

    // Backpressure: four words, consumer stalls for three cycles.
    a = 64'hDEADBEEF00000001; b = 64'h1111111111111111;
    c = 64'h2222222222222222; e = 64'h3333333333333333;
    w0 = flip(enc(a), 5); w1 = enc(b); w2 = enc(c); w3 = enc(e);
    dec_data_in = w0; dec_in_valid = 1'b1;
    step();
    dec_data_in = w1;
    step();
    dec_data_in = w2; dec_out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready", 64'(dec_in_ready), 64'd0);
      chk("bp frozen data", dec_data_out, a);
      chk("bp frozen flags", 64'({dec_out_valid, dec_err_single, dec_syndrome}),
          64'({1'b1, 1'b1, 7'd5}));
      chk("bp ce held", 64'(ce_count), 64'd0);
      step();
    end
    dec_out_ready = 1'b1;
    #1;
    chk("bp resume in_ready", 64'(dec_in_ready), 64'd1);
    chk("bp resume w0", dec_data_out, a);
    step();
    dec_data_in = w3;
    #1;
    chk("bp w1", dec_data_out, b);
    chk("bp w1 single", 64'(dec_err_single), 64'd0);
    step();
    dec_in_valid = 1'b0;
    #1;
    chk("bp w2", dec_data_out, c);
    step();
    chk("bp w3", dec_data_out, e);
    chk("bp w3 valid", 64'(dec_out_valid), 64'd1);
    step();
    chk("bp drained", 64'(dec_out_valid), 64'd0);
    chk("bp ce once", 64'(ce_count), 64'd1);

    // Reset with two words in flight.
    dec_data_in = flip(enc(d), 3); dec_in_valid = 1'b1;
    step();
    dec_data_in = enc(b);
    step();
    chk("mid valid", 64'(dec_out_valid), 64'd1);
    rst = 1'b1; dec_in_valid = 1'b0;
    step();
    chk("mid rst valid", 64'(dec_out_valid), 64'd0);
    chk("mid rst in_ready", 64'(dec_in_ready), 64'd1);
    chk("mid rst counters", 64'({ce_count, ue_count}), 64'd0);
    chk("mid rst data", dec_data_out, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post rst no output", 64'({dec_out_valid, ce_count}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ecc_decoder_pipe.md
Name: ecc_decoder_pipe

Overview:
- Pipelined SECDED Hamming decoder/corrector, directly downstream of the memory array on the read path.
- Consumes codewords produced by ecc_encoder after storage, recomputes syndrome and overall parity, corrects single-bit errors and flags double-bit errors.
- Two register stages with valid/ready backpressure; saturating correctable/uncorrectable error counters for scrub and telemetry logic.

Parameters:
- data_bit_width, 64, payload bits per codeword.
- redundant_bit_width, 8, check bits (1 overall parity plus redundant_bit_width-1 Hamming bits). Must satisfy 2**(redundant_bit_width-1) >= data_bit_width+redundant_bit_width.
- counter_width, 16, width of each error counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- dec_data_in  input  data_bit_width+redundant_bit_width  codeword from memory.
- dec_in_valid  input  1  codeword valid.
- dec_in_ready  output  1  decoder accepts this cycle.
- dec_data_out  output  data_bit_width  corrected payload.
- dec_out_valid  output  1  output valid.
- dec_out_ready  input  1  consumer accepts.
- dec_err_single  output  1  single error corrected on this word.
- dec_err_double  output  1  uncorrectable error on this word; payload passed raw.
- dec_syndrome  output  redundant_bit_width-1  Hamming syndrome of this word.
- ce_count  output  counter_width  saturating count of single errors.
- ue_count  output  counter_width  saturating count of uncorrectable errors.
- cnt_clear  input  1  synchronous clear of both counters.

Behaviour:
- Codeword layout (N = data_bit_width+redundant_bit_width):
  - Position 0 is the overall parity.
  - Position 2**(k-1) holds Hamming bit k, for k = 1..redundant_bit_width-1.
  - All remaining positions hold data bits in ascending order: data bit 0 at position 3, bit 1 at 5, bit 2 at 6, bit 3 at 7, bit 4 at 9, ...
- Syndrome: s[k-1] = XOR of every codeword bit whose position index has bit (k-1) set, including the check bit itself.
- Overall parity: p = XOR of all N bits.
- Stage 1 registers the incoming codeword, s and p. Stage 2 registers the corrected data and flags.
- Classification:
  - s==0, p==0: clean. Both flags 0.
  - p==1, s<N: single error. Flip position s; s==0 means the overall parity bit was flipped. Data is unchanged when s is a check-bit position. Set dec_err_single.
  - s!=0, p==0: double error. Set dec_err_double. Data is extracted uncorrected.
  - p==1, s>=N: position out of range. Treat as uncorrectable and set dec_err_double.
  - dec_err_single and dec_err_double are never both 1.
- Handshake:
  - en = !dec_out_valid || dec_out_ready; dec_in_ready = en.
  - On en, both stages shift: stage1 <= input and its valid bit; stage2 <= stage1.
  - When en==0, every output stays stable.
  - Bubbles propagate, so an accepted word appears at the output after exactly 2 enabled cycles.
  - Sustained throughput is 1 word/cycle with dec_out_ready held high.
  - Input transfer is dec_in_valid && dec_in_ready; output transfer is dec_out_valid && dec_out_ready.
- Counters:
  - Increment on an output transfer carrying the matching flag.
  - Saturate at all-ones, with no wrap.
  - If cnt_clear and an increment occur in the same cycle, clear wins and the counter becomes 0.
- Reset:
  - Clears both stage valid bits.
  - Outputs after reset: dec_out_valid=0, dec_data_out=0, both flags 0, dec_syndrome=0, ce_count=0, ue_count=0.
  - dec_in_ready=1 in the first cycle after reset.
  - Reset asserted mid-stream discards in-flight words; they are neither output nor counted.

Test Plan:
- Clean word: encode 0x0123456789ABCDEF, hold dec_out_ready=1 -> output 0x0123456789ABCDEF two cycles after accept; flags 0; syndrome 0; counters unchanged.
- Single data error: flip codeword position 3 of the same word -> data corrected to 0x0123456789ABCDEF; dec_syndrome=3; dec_err_single=1; ce_count=1.
- Parity-bit errors:
  - Flip position 0 -> syndrome 0, dec_err_single=1, data correct.
  - Flip position 64 -> syndrome 64, dec_err_single=1, data correct.
- Double error: flip positions 3 and 5 -> syndrome 6, dec_err_double=1, dec_err_single=0, ue_count increments by 1.
- Out-of-range single: flip positions 1, 2 and 127-derived bits so that p=1 and s>=72 -> dec_err_double=1.
- Backpressure and reset:
  - Stream 4 words and drop dec_out_ready for 3 cycles -> dec_in_ready=0, outputs frozen, no loss or duplication; order preserved on resume.
  - Assert rst with 2 words in flight -> dec_out_valid=0 next cycle; counters 0.
- Saturation and clear: counter_width=2, send 5 single-error words -> ce_count=3. Pulse cnt_clear in the same cycle as a 6th single-error transfer -> ce_count=0.
